// File: rtl/rice_core_writeback_arbiter.sv
// Writeback arbiter: round-robin merge of execute and load results onto the
// single register-file write port, plus a per-register pending-write scoreboard.
module rice_core_writeback_arbiter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_ex_valid,
  input  logic [4:0]      i_ex_rd,
  input  logic [XLEN-1:0] i_ex_value,
  output logic            o_ex_ready,
  input  logic            i_mem_valid,
  input  logic [4:0]      i_mem_rd,
  input  logic [XLEN-1:0] i_mem_value,
  output logic            o_mem_ready,
  input  logic            i_issue_valid,
  input  logic [4:0]      i_issue_rd,
  output logic            o_wb_valid,
  output logic [4:0]      o_wb_rd,
  output logic [XLEN-1:0] o_wb_value,
  output logic [31:0]     o_busy
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned NREGS  = 32;

  typedef enum logic {
    GRANT_EX  = 1'b0,
    GRANT_MEM = 1'b1
  } grant_e;

  grant_e            last_grant_q, last_grant_d;
  logic              wb_valid_q, wb_valid_d;
  logic [REG_W-1:0]  wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]   wb_value_q, wb_value_d;
  logic [NREGS-1:0]  busy_q, busy_d;

  logic              ex_ready_c;
  logic              mem_ready_c;
  logic              accept_c;
  logic [REG_W-1:0]  sel_rd_c;
  logic [XLEN-1:0]   sel_value_c;

  // Grant: a lone requester wins outright; on contention the one not served last wins.
  always_comb begin
    ex_ready_c  = 1'b0;
    mem_ready_c = 1'b0;
    if (!i_rst) begin
      ex_ready_c  = i_ex_valid  && (!i_mem_valid || last_grant_q == GRANT_MEM);
      mem_ready_c = i_mem_valid && (!i_ex_valid  || last_grant_q == GRANT_EX);
    end
    accept_c    = ex_ready_c || mem_ready_c;
    sel_rd_c    = mem_ready_c ? i_mem_rd    : i_ex_rd;
    sel_value_c = mem_ready_c ? i_mem_value : i_ex_value;
  end

  // Next-state for the writeback register, grant history and scoreboard.
  always_comb begin
    last_grant_d = last_grant_q;
    wb_valid_d   = 1'b0;
    wb_rd_d      = wb_rd_q;
    wb_value_d   = wb_value_q;
    busy_d       = busy_q;

    if (accept_c) begin
      last_grant_d     = mem_ready_c ? GRANT_MEM : GRANT_EX;
      wb_valid_d       = (sel_rd_c != REG_W'(0));
      wb_rd_d          = sel_rd_c;
      wb_value_d       = sel_value_c;
      busy_d[sel_rd_c] = 1'b0;
    end
    // Issue applied after the clear so a new producer keeps the bit set.
    if (i_issue_valid && i_issue_rd != REG_W'(0)) begin
      busy_d[i_issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_grant_q <= GRANT_MEM;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_value_q   <= '0;
      busy_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      wb_valid_q   <= wb_valid_d;
      wb_rd_q      <= wb_rd_d;
      wb_value_q   <= wb_value_d;
      busy_q       <= busy_d;
    end
  end

  assign o_ex_ready  = ex_ready_c;
  assign o_mem_ready = mem_ready_c;
  assign o_wb_valid  = wb_valid_q;
  assign o_wb_rd     = wb_rd_q;
  assign o_wb_value  = wb_value_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_rice_core_writeback_arbiter.sv
// Directed bench for the writeback arbiter: grant order, latency, scoreboard, reset.
module tb_rice_core_writeback_arbiter;

  localparam int unsigned XLEN = 32;

  logic            i_clk;
  logic            i_rst;
  logic            i_ex_valid;
  logic [4:0]      i_ex_rd;
  logic [XLEN-1:0] i_ex_value;
  logic            o_ex_ready;
  logic            i_mem_valid;
  logic [4:0]      i_mem_rd;
  logic [XLEN-1:0] i_mem_value;
  logic            o_mem_ready;
  logic            i_issue_valid;
  logic [4:0]      i_issue_rd;
  logic            o_wb_valid;
  logic [4:0]      o_wb_rd;
  logic [XLEN-1:0] o_wb_value;
  logic [31:0]     o_busy;

  int n_cmp;
  int n_bad;

  rice_core_writeback_arbiter #(.XLEN(XLEN)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_ex_valid    (i_ex_valid),
    .i_ex_rd       (i_ex_rd),
    .i_ex_value    (i_ex_value),
    .o_ex_ready    (o_ex_ready),
    .i_mem_valid   (i_mem_valid),
    .i_mem_rd      (i_mem_rd),
    .i_mem_value   (i_mem_value),
    .o_mem_ready   (o_mem_ready),
    .i_issue_valid (i_issue_valid),
    .i_issue_rd    (i_issue_rd),
    .o_wb_valid    (o_wb_valid),
    .o_wb_rd       (o_wb_rd),
    .o_wb_value    (o_wb_value),
    .o_busy        (o_busy)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  // Let combinational readies settle before sampling.
  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    i_ex_valid    = 1'b0;
    i_mem_valid   = 1'b0;
    i_issue_valid = 1'b0;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    next_cycle();
    next_cycle();
    i_rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    i_rst = 1'b1;
    i_ex_valid = 1'b0; i_ex_rd = '0; i_ex_value = '0;
    i_mem_valid = 1'b0; i_mem_rd = '0; i_mem_value = '0;
    i_issue_valid = 1'b0; i_issue_rd = '0;

    // Reset: readies forced low even with both requesting; outputs cleared.
    next_cycle();
    i_ex_valid = 1'b1; i_ex_rd = 5'd3; i_ex_value = 32'h1111_1111;
    i_mem_valid = 1'b1; i_mem_rd = 5'd4; i_mem_value = 32'h2222_2222;
    settle();
    check("rst_ex_ready", 32'(o_ex_ready), 32'd0);
    check("rst_mem_ready", 32'(o_mem_ready), 32'd0);
    next_cycle();
    idle_inputs();
    settle();
    check("rst_wb_valid", 32'(o_wb_valid), 32'd0);
    check("rst_busy", o_busy, 32'd0);
    check("rst_wb_rd", 32'(o_wb_rd), 32'd0);
    check("rst_wb_value", o_wb_value, 32'd0);
    i_rst = 1'b0;

    // Single ex request: granted same cycle, one-cycle writeback pulse next cycle.
    next_cycle();
    i_ex_valid = 1'b1; i_ex_rd = 5'd5; i_ex_value = 32'hDEAD_BEEF;
    settle();
    check("single_ex_ready", 32'(o_ex_ready), 32'd1);
    check("single_mem_ready", 32'(o_mem_ready), 32'd0);
    next_cycle();
    idle_inputs();
    settle();
    check("single_wb_valid", 32'(o_wb_valid), 32'd1);
    check("single_wb_rd", 32'(o_wb_rd), 32'd5);
    check("single_wb_value", o_wb_value, 32'hDEAD_BEEF);
    check("single_ex_ready_idle", 32'(o_ex_ready), 32'd0);
    next_cycle();
    settle();
    check("single_wb_pulse_end", 32'(o_wb_valid), 32'd0);

    // Contention from reset: ex, mem, ex, mem.
    do_reset();
    i_ex_valid = 1'b1; i_ex_rd = 5'd1; i_ex_value = 32'h0000_0A01;
    i_mem_valid = 1'b1; i_mem_rd = 5'd2; i_mem_value = 32'h0000_0B02;
    for (int k = 0; k < 4; k++) begin
      settle();
      check($sformatf("rr_ex_ready_%0d", k), 32'(o_ex_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("rr_mem_ready_%0d", k), 32'(o_mem_ready), (k % 2 == 0) ? 32'd0 : 32'd1);
      if (k > 0) begin
        check($sformatf("rr_wb_rd_%0d", k - 1), 32'(o_wb_rd), (k % 2 == 1) ? 32'd1 : 32'd2);
        check($sformatf("rr_wb_valid_%0d", k - 1), 32'(o_wb_valid), 32'd1);
      end
      next_cycle();
    end
    idle_inputs();
    settle();
    check("rr_wb_rd_3", 32'(o_wb_rd), 32'd2);
    check("rr_wb_value_3", o_wb_value, 32'h0000_0B02);

    // Scoreboard set by issue, cleared by mem writeback in the pulse cycle.
    next_cycle();
    i_issue_valid = 1'b1; i_issue_rd = 5'd7;
    next_cycle();
    i_issue_valid = 1'b0;
    settle();
    check("sb_set_7", o_busy, 32'h0000_0080);
    next_cycle();
    i_mem_valid = 1'b1; i_mem_rd = 5'd7; i_mem_value = 32'hCAFE_0007;
    settle();
    check("sb_mem_ready_7", 32'(o_mem_ready), 32'd1);
    check("sb_still_set_7", o_busy, 32'h0000_0080);
    next_cycle();
    idle_inputs();
    settle();
    check("sb_clear_7", o_busy, 32'd0);
    check("sb_wb_valid_7", 32'(o_wb_valid), 32'd1);
    check("sb_wb_rd_7", 32'(o_wb_rd), 32'd7);

    // Same-cycle issue and writeback of rd 9: set wins.
    i_issue_valid = 1'b1; i_issue_rd = 5'd9;
    next_cycle();
    i_issue_valid = 1'b1; i_issue_rd = 5'd9;
    i_ex_valid = 1'b1; i_ex_rd = 5'd9; i_ex_value = 32'h0000_0999;
    settle();
    check("coll_busy_before", o_busy, 32'h0000_0200);
    check("coll_ex_ready", 32'(o_ex_ready), 32'd1);
    next_cycle();
    idle_inputs();
    settle();
    check("coll_wb_valid", 32'(o_wb_valid), 32'd1);
    check("coll_wb_rd", 32'(o_wb_rd), 32'd9);
    check("coll_busy_kept", o_busy, 32'h0000_0200);

    // rd 0: accepted but no write pulse; issue of rd 0 never marks busy.
    i_ex_valid = 1'b1; i_ex_rd = 5'd0; i_ex_value = 32'h0000_1234;
    settle();
    check("r0_ex_ready", 32'(o_ex_ready), 32'd1);
    next_cycle();
    i_ex_valid = 1'b0;
    i_mem_valid = 1'b1; i_mem_rd = 5'd9; i_mem_value = 32'h0000_0009;
    settle();
    check("r0_no_wb", 32'(o_wb_valid), 32'd0);
    next_cycle();
    idle_inputs();
    i_issue_valid = 1'b1; i_issue_rd = 5'd0;
    next_cycle();
    idle_inputs();
    settle();
    check("r0_busy_zero", o_busy, 32'd0);

    // Build busy = 0xF00 with last grant = ex, then reset mid-contention.
    for (int r = 8; r < 12; r++) begin
      idle_inputs();
      i_issue_valid = 1'b1; i_issue_rd = 5'(r);
      if (r == 8) begin
        i_ex_valid = 1'b1; i_ex_rd = 5'd5; i_ex_value = 32'h0000_0055;
      end
      next_cycle();
    end
    idle_inputs();
    settle();
    check("pre_rst_busy", o_busy, 32'h0000_0F00);
    i_ex_valid = 1'b1; i_ex_rd = 5'd3; i_ex_value = 32'h0000_0333;
    i_mem_valid = 1'b1; i_mem_rd = 5'd4; i_mem_value = 32'h0000_0444;
    i_rst = 1'b1;
    settle();
    check("mid_rst_ex_ready", 32'(o_ex_ready), 32'd0);
    check("mid_rst_mem_ready", 32'(o_mem_ready), 32'd0);
    next_cycle();
    i_rst = 1'b0;
    settle();
    check("post_rst_busy", o_busy, 32'd0);
    check("post_rst_wb_valid", 32'(o_wb_valid), 32'd0);
    check("post_rst_ex_first", 32'(o_ex_ready), 32'd1);
    check("post_rst_mem_wait", 32'(o_mem_ready), 32'd0);
    next_cycle();
    settle();
    check("post_rst_mem_next", 32'(o_mem_ready), 32'd1);
    check("post_rst_wb_rd", 32'(o_wb_rd), 32'd3);
    idle_inputs();
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
